// File: rtl/noc_pkg.sv
// ============================================================================
// Module  : noc_pkg
// Brief   : Shared flit types, type-field geometry and head-flit packing for
//           the tile network interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int NOC_FLIT_W = 64;
    // Widest flit the head packer supports.
    localparam int NOC_PACK_W = 256;
    // The type field occupies the NOC_TYPE_W most significant bits of a flit.
    localparam int NOC_TYPE_W = 2;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } noc_flit_type_e;

    function automatic logic [NOC_PACK_W-1:0] noc_field(input logic [31:0] v,
                                                        input int unsigned w);
        return NOC_PACK_W'(v) & ((NOC_PACK_W'(1) << w) - NOC_PACK_W'(1));
    endfunction

    // Fields are packed MSB-first, then shifted so the type lands at flit_w-1.
    function automatic logic [NOC_PACK_W-1:0] noc_pack_head(
        input int unsigned    flit_w,
        input int unsigned    rw,
        input int unsigned    cw,
        input int unsigned    lw,
        input noc_flit_type_e ft,
        input logic [31:0]    dst_r,
        input logic [31:0]    dst_c,
        input logic [31:0]    src_r,
        input logic [31:0]    src_c,
        input logic [31:0]    len
    );
        logic [NOC_PACK_W-1:0] f;
        f = NOC_PACK_W'(ft);
        f = (f << rw) | noc_field(dst_r, rw);
        f = (f << cw) | noc_field(dst_c, cw);
        f = (f << rw) | noc_field(src_r, rw);
        f = (f << cw) | noc_field(src_c, cw);
        f = (f << lw) | noc_field(len, lw);
        return f << (flit_w - NOC_TYPE_W - 2 * rw - 2 * cw - lw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_flit_reg.sv
// ============================================================================
// Module  : noc_flit_reg
// Brief   : Valid/ready output holding register; loads when empty or draining.
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_flit_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_free
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_free) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_tile_packetizer.sv
// ============================================================================
// Module  : noc_tile_packetizer
// Brief   : NI transmit stage: turns a request plus payload stream into
//           HEAD/BODY/TAIL (or SINGLE) flits. Optional counters: NOC_NI_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_tile_packetizer
    import noc_pkg::*;
#(
    parameter int   FLIT_W = NOC_FLIT_W,
    parameter int   ROWS   = 4,
    parameter int   COLS   = 4,
    parameter int   R      = 0,
    parameter int   C      = 0,
    parameter int   LEN_W  = 4,
    localparam int  RW     = $clog2(ROWS),
    localparam int  CW     = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RW-1:0]     req_dst_r,
    input  logic [CW-1:0]     req_dst_c,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [FLIT_W-3:0] pl_data,
    output logic [FLIT_W-1:0] flit_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              err_dst,
`ifdef NOC_NI_STATS_EN
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       flit_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    logic [1:0]        r_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [RW-1:0]     r_dst_r;
    logic [CW-1:0]     r_dst_c;
    logic [LEN_W-1:0]  r_len;
    logic              r_err;

    logic              w_free;
    logic              w_req_fire;
    logic              w_dst_bad;
    logic              w_pl_fire;
    logic              w_load;
    logic [FLIT_W-1:0] w_flit;
    noc_flit_type_e    w_body_type;

    assign req_ready   = (r_state == S_IDLE) && w_free;
    assign pl_ready    = (r_state == S_BODY) && w_free;
    assign w_req_fire  = req_valid && req_ready;
    assign w_pl_fire   = pl_valid && pl_ready;
    assign w_dst_bad   = ({1'b0, req_dst_r} >= (RW+1)'(ROWS)) ||
                         ({1'b0, req_dst_c} >= (CW+1)'(COLS));
    assign w_body_type = (r_remaining == LEN_W'(1)) ? FT_TAIL : FT_BODY;
    assign err_dst     = r_err;
    assign busy        = (r_state != S_IDLE) || valid_out;

    always_comb begin
        w_load = 1'b0;
        w_flit = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire && !w_dst_bad) begin
                    w_load = 1'b1;
                    w_flit = FLIT_W'(noc_pack_head(FLIT_W, RW, CW, LEN_W,
                                 (req_len == '0) ? FT_SINGLE : FT_HEAD,
                                 32'(req_dst_r), 32'(req_dst_c),
                                 32'(R), 32'(C), 32'(req_len)));
                end
            end
            S_HEAD: begin
                w_load = w_free;
                w_flit = FLIT_W'(noc_pack_head(FLIT_W, RW, CW, LEN_W, FT_HEAD,
                             32'(r_dst_r), 32'(r_dst_c),
                             32'(R), 32'(C), 32'(r_len)));
            end
            S_BODY: begin
                w_load = w_pl_fire;
                w_flit = {w_body_type, pl_data};
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_dst_r     <= '0;
            r_dst_c     <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_req_fire && w_dst_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire && !w_dst_bad) begin
                        r_dst_r <= req_dst_r;
                        r_dst_c <= req_dst_c;
                        r_len   <= req_len;
                        if (req_len != '0) begin
                            r_remaining <= req_len;
                            r_state     <= S_BODY;
                        end
                    end
                end
                S_HEAD: begin
                    if (w_free) begin
                        r_remaining <= r_len;
                        r_state     <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_pl_fire) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    noc_flit_reg #(
        .W (FLIT_W)
    ) u_flit_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_flit),
        .i_ready (ready_in),
        .o_data  (flit_out),
        .o_valid (valid_out),
        .o_free  (w_free)
    );

`ifdef NOC_NI_STATS_EN
    logic        w_hs;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_flit_cnt;
    logic [15:0] r_drop_cnt;

    assign w_hs     = valid_out && ready_in;
    assign pkt_cnt  = r_pkt_cnt;
    assign flit_cnt = r_flit_cnt;
    assign drop_cnt = r_drop_cnt;

    // HEAD and SINGLE both have the low type bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_flit_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_flit_cnt <= r_flit_cnt + 32'd1;
                if (flit_out[FLIT_W-NOC_TYPE_W]) begin
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
            end
            if (w_req_fire && w_dst_bad && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_tile_packetizer.sv
// ============================================================================
// Module  : tb_noc_tile_packetizer
// Brief   : Directed bench with a flit-queue model for noc_tile_packetizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_noc_tile_packetizer;

    // ROWS=5 makes dst_r=ROWS representable in the 3-bit row field.
    localparam int FW   = 64;
    localparam int ROWS = 5;
    localparam int COLS = 4;
    localparam int R    = 2;
    localparam int C    = 1;
    localparam int LW   = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_dst_r;
    logic [1:0]    req_dst_c;
    logic [LW-1:0] req_len;
    logic          pl_valid;
    logic          pl_ready;
    logic [FW-3:0] pl_data;
    logic [FW-1:0] flit_out;
    logic          valid_out;
    logic          ready_in;
    logic          err_dst;
    logic          busy;
`ifdef NOC_NI_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   flit_cnt;
    logic [15:0]   drop_cnt;
`endif

    noc_tile_packetizer #(
        .FLIT_W (FW),
        .ROWS   (ROWS),
        .COLS   (COLS),
        .R      (R),
        .C      (C),
        .LEN_W  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dst_r (req_dst_r),
        .req_dst_c (req_dst_c),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .flit_out  (flit_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .err_dst   (err_dst),
`ifdef NOC_NI_STATS_EN
        .pkt_cnt   (pkt_cnt),
        .flit_cnt  (flit_cnt),
        .drop_cnt  (drop_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          n_err  = 0;
    logic [63:0] exp_q[$];
    int          hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Head flit: type, dst_r(3), dst_c(2), src_r(3), src_c(2), len(4), zeros.
    function automatic logic [63:0] m_head(input logic [31:0] dr, input logic [31:0] dc,
                                           input logic [31:0] len);
        logic [1:0]  t;
        logic [31:0] sr;
        logic [31:0] sc;
        t  = (len == 0) ? 2'b11 : 2'b01;
        sr = R;
        sc = C;
        return {t, dr[2:0], dc[1:0], sr[2:0], sc[1:0], len[3:0], 48'd0};
    endfunction

    function automatic logic [61:0] pw(input logic [31:0] pkt, input int i);
        return {pkt[29:0], 32'hA5A5_0000 + 32'(i)};
    endfunction

    task automatic expect_pkt(input int pkt, input int dr, input int dc, input int len);
        exp_q.push_back(m_head(dr, dc, len));
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1) ? 2'b10 : 2'b00, pw(pkt, i)});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input int dr, input int dc, input int len);
        bit acc;
        acc       = 1'b0;
        req_dst_r = 3'(dr);
        req_dst_c = 2'(dc);
        req_len   = 4'(len);
        req_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: got no req_ready required req_ready=1");
        end
    endtask

    task automatic send_pl(input int pkt, input int len);
        bit taken;
        for (int i = 0; i < len; i++) begin
            pl_valid = 1'b1;
            pl_data  = pw(pkt, i);
            taken    = 1'b0;
            for (int k = 0; k < 50 && !taken; k++) begin
                @(negedge clk);
                taken = pl_ready;
                @(posedge clk);
                #1;
            end
            if (!taken) begin
                n_chk++;
                n_fail++;
                $display("FAIL pl_timeout: got no pl_ready required pl_ready=1 (word %0d)", i);
            end
        end
        pl_valid = 1'b0;
    endtask

    // Compare process: every handshake is checked against the flit queue,
    // and a stalled output must hold its value.
    initial begin
        logic        pv;
        logic        pr;
        logic [63:0] pf;
        pv = 1'b0;
        pr = 1'b0;
        pf = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("stall_valid", 64'(valid_out), 64'd1);
                    chk("stall_flit", flit_out, pf);
                end
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_flit: got %h required no flit", flit_out);
                    end else begin
                        chk("flit", flit_out, exp_q.pop_front());
                    end
                    hs_cyc.push_back(cyc);
                end
                if (err_dst) n_err++;
                pv = valid_out;
                pr = ready_in;
                pf = flit_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_dst_r = '0;
        req_dst_c = '0;
        req_len   = '0;
        pl_valid  = 1'b0;
        pl_data   = '0;
        ready_in  = 1'b1;
        tick(3);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_flit", flit_out, 64'd0);
        chk("rst_err", 64'(err_dst), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pl_ready", 64'(pl_ready), 64'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // dst (1,2), len 3: head + A,B,C on consecutive cycles
        base = hs_cyc.size();
        expect_pkt(1, 1, 2, 3);
        chk("t1_pre_valid", 64'(valid_out), 64'd0);
        do_req(1, 2, 3);
        chk("t1_latency_valid", 64'(valid_out), 64'd1);
        chk("t1_head_literal", flit_out, 64'h4C93_0000_0000_0000);
        send_pl(1, 3);
        tick(3);
        chk("t1_nflits", 64'(hs_cyc.size() - base), 64'd4);
        if (hs_cyc.size() >= base + 4)
            chk("t1_consecutive", 64'(hs_cyc[base+3] - hs_cyc[base]), 64'd3);

        // single flit to (3,3)
        expect_pkt(2, 3, 3, 0);
        do_req(3, 3, 0);
        chk("t2_single_literal", flit_out, 64'hDE90_0000_0000_0000);
        chk("t2_req_ready_again", 64'(req_ready), 64'd1);
        tick(2);
        chk("t2_idle_busy", 64'(busy), 64'd0);

        // out-of-range destination row
        e0       = n_err;
        pl_valid = 1'b1;
        pl_data  = pw(3, 0);
        do_req(ROWS, 0, 2);
        chk("t3_err_pulse", 64'(err_dst), 64'd1);
        chk("t3_no_valid", 64'(valid_out), 64'd0);
        chk("t3_pl_ready", 64'(pl_ready), 64'd0);
        tick(1);
        chk("t3_err_clear", 64'(err_dst), 64'd0);
        chk("t3_pl_ready2", 64'(pl_ready), 64'd0);
        chk("t3_no_valid2", 64'(valid_out), 64'd0);
        pl_valid = 1'b0;
        chk("t3_err_count", 64'(n_err - e0), 64'd1);

        // len 2 with downstream stalled for 5 cycles after HEAD
        ready_in = 1'b0;
        expect_pkt(4, 2, 1, 2);
        do_req(2, 1, 2);
        pl_valid = 1'b1;
        pl_data  = pw(4, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_pl_ready", 64'(pl_ready), 64'd0);
            chk("t4_stall_head", flit_out, m_head(2, 1, 2));
            tick(1);
        end
        ready_in = 1'b1;
        send_pl(4, 2);
        tick(3);

        // reset after the 2nd body flit of a len-5 packet
        expect_pkt(5, 4, 3, 5);
        do_req(4, 3, 5);
        send_pl(5, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(valid_out), 64'd0);
        chk("t5_rst_flit", flit_out, 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        expect_pkt(6, 0, 0, 1);
        do_req(0, 0, 1);
        chk("t5_post_valid", 64'(valid_out), 64'd1);
        send_pl(6, 1);
        tick(3);

        // counters: packets of len 0, 2, 5 and one dropped request
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        expect_pkt(7, 0, 1, 0);
        do_req(0, 1, 0);
        expect_pkt(8, 1, 0, 2);
        do_req(1, 0, 2);
        send_pl(8, 2);
        expect_pkt(9, 4, 2, 5);
        do_req(4, 2, 5);
        send_pl(9, 5);
        do_req(ROWS + 1, 3, 1);
        tick(3);
`ifdef NOC_NI_STATS_EN
        chk("st_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("st_flit_cnt", 64'(flit_cnt), 64'd10);
        chk("st_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("total_err_pulses", 64'(n_err), 64'd2);
        chk("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
